spi_reg_bridge: RTL and testbench

//  Byte-stream consumer sitting directly downstream of the SPI slave front-end. Decodes

---
 rtl/spi_reg_bridge.sv | 151 +++++++++++++++
 tb/tb_spi_reg_bridge.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: turns the SPI slave byte stream into register-bus transactions.
// Byte 0 of a frame is a command (bit 7 = write, low bits = address). A write frame
// then carries any number of data bytes that go to consecutive addresses. A read frame
// performs one bus read and hands the data back to the front-end for the next frame.
//
// state   | meaning
// S_CMD   | waiting for the command byte of a frame
// S_WDATA | write frame, waiting for the next data byte
// S_WREQ  | bus_we held, waiting for bus_ack or timeout
// S_RREQ  | bus_re held, waiting for bus_ack or timeout
// S_DRAIN | read done, ignore the rest of the frame
module spi_reg_bridge #(
  parameter int         ADDR_WIDTH = 7,
  parameter int         TIMEOUT    = 255,
  parameter logic [7:0] ERR_BYTE   = 8'hEE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  tx_valid,
  output logic [7:0]            tx_data,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wdata,
  output logic                  bus_we,
  output logic                  bus_re,
  input  logic [7:0]            bus_rdata,
  input  logic                  bus_ack,
  output logic                  err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_CMD   = 3'd0,
    S_WDATA = 3'd1,
    S_WREQ  = 3'd2,
    S_RREQ  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t          state;
  logic            cs_meta, cs_sync, cs_prev;
  logic            frame_end;
  logic            end_pending;
  logic [CW-1:0]   tmo_cnt;
  logic            tmo_hit;
  logic            pend_end;

  // The request has been held for TIMEOUT cycles once the count reaches TIMEOUT-1.
  assign tmo_hit  = (tmo_cnt == CW'(TIMEOUT - 1));
  // Frame has ended either earlier during this request or in this very cycle.
  assign pend_end = end_pending | frame_end;

  // Synchronise cs and register the rising edge so the FSM acts one cycle after detection.
  // Idle-high reset values keep a spurious edge from appearing out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      cs_prev   <= 1'b1;
      frame_end <= 1'b0;
    end else begin
      cs_meta   <= cs;
      cs_sync   <= cs_meta;
      cs_prev   <= cs_sync;
      frame_end <= cs_sync & ~cs_prev;
    end
  end

  // Frame decode, bus request handshake, timeout and error tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_CMD;
      tx_valid    <= 1'b0;
      tx_data     <= 8'h00;
      bus_addr    <= '0;
      bus_wdata   <= 8'h00;
      bus_we      <= 1'b0;
      bus_re      <= 1'b0;
      err         <= 1'b0;
      end_pending <= 1'b0;
      tmo_cnt     <= '0;
    end else begin
      tx_valid <= 1'b0;
      if (frame_end) end_pending <= 1'b0;
      case (state)
        S_CMD: begin
          if (rx_valid) begin
            bus_addr <= rx_data[ADDR_WIDTH-1:0];
            if (rx_data[7]) begin
              state <= frame_end ? S_CMD : S_WDATA;
            end else begin
              state       <= S_RREQ;
              bus_re      <= 1'b1;
              tmo_cnt     <= '0;
              end_pending <= frame_end;
            end
          end else if (frame_end) begin
            state <= S_CMD;
          end
        end
        S_WDATA: begin
          if (rx_valid) begin
            bus_wdata   <= rx_data;
            state       <= S_WREQ;
            bus_we      <= 1'b1;
            tmo_cnt     <= '0;
            end_pending <= frame_end;
          end else if (frame_end) begin
            state <= S_CMD;
          end
        end
        S_WREQ: begin
          if (rx_valid) err <= 1'b1;
          if (frame_end) end_pending <= 1'b1;
          if (bus_ack || tmo_hit) begin
            bus_we      <= 1'b0;
            bus_addr    <= bus_addr + ADDR_WIDTH'(1);
            if (!bus_ack) err <= 1'b1;
            state       <= pend_end ? S_CMD : S_WDATA;
            end_pending <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        S_RREQ: begin
          if (rx_valid) err <= 1'b1;
          if (frame_end) end_pending <= 1'b1;
          if (bus_ack || tmo_hit) begin
            bus_re      <= 1'b0;
            bus_addr    <= bus_addr + ADDR_WIDTH'(1);
            tx_valid    <= 1'b1;
            tx_data     <= bus_ack ? bus_rdata : ERR_BYTE;
            if (!bus_ack) err <= 1'b1;
            state       <= pend_end ? S_CMD : S_DRAIN;
            end_pending <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + CW'(1);
          end
        end
        S_DRAIN: begin
          if (frame_end) state <= S_CMD;
        end
        default: state <= S_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: a bus responder with a memory model acks
// requests after a programmable delay; expected writes and read data are derived from
// the frame bytes with plain address arithmetic.
module tb_spi_reg_bridge;
  localparam int AW = 7;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst, cs, rx_valid;
  logic [7:0]    rx_data;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic [AW-1:0] bus_addr;
  logic [7:0]    bus_wdata;
  logic          bus_we, bus_re;
  logic [7:0]    bus_rdata;
  logic          bus_ack;
  logic          err;

  spi_reg_bridge #(.ADDR_WIDTH(AW), .TIMEOUT(TO), .ERR_BYTE(8'hEE)) dut (
    .clk(clk), .rst(rst), .cs(cs), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .err(err)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            ack_delay = 2;
  bit            ack_en    = 1'b1;
  bit            force_ack = 1'b0;
  logic [7:0]    mem [128];
  logic [AW-1:0] wlog_addr[$];
  logic [7:0]    wlog_data[$];
  logic [AW-1:0] exp_addr[$];
  logic [7:0]    exp_data[$];
  logic [7:0]    frame_q[$];
  int            tx_cnt = 0;
  int            re_starts = 0;
  logic [7:0]    tx_last = 8'h00;

  // Bus responder and output monitor, sampling 1 time unit after each rising edge.
  initial begin
    int wc;
    bit prev_re;
    wc = 0; prev_re = 1'b0; bus_ack = 1'b0; bus_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      bus_ack = 1'b0;
      if (tx_valid) begin tx_cnt++; tx_last = tx_data; end
      if (bus_re && !prev_re) re_starts++;
      prev_re = bus_re;
      n_checks++;
      if (bus_we && bus_re) begin
        n_fail++;
        $display("FAIL we_re_overlap: bus_we=%b bus_re=%b, required not both 1", bus_we, bus_re);
      end
      if (force_ack) bus_ack = 1'b1;
      else if ((bus_we || bus_re) && ack_en) begin
        if (wc >= ack_delay) begin
          bus_ack   = 1'b1;
          bus_rdata = mem[bus_addr];
          if (bus_we) begin wlog_addr.push_back(bus_addr); wlog_data.push_back(bus_wdata); end
          wc = 0;
        end else wc++;
      end else wc = 0;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bus_we || bus_re) && n < 100) begin tick(); n++; end
    n_checks++;
    if (n >= 100) begin
      n_fail++;
      $display("FAIL wait_idle: request still held after %0d cycles, required release", n);
    end
    tick(2);
  endtask

  task automatic frame_begin(); cs = 1'b0; tick(3); endtask
  task automatic frame_close(); cs = 1'b1; tick(6); endtask

  task automatic send_frame();
    frame_begin();
    foreach (frame_q[i]) begin send_byte(frame_q[i]); wait_idle(); end
    frame_close();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(3); rst = 1'b0; tick(2);
  endtask

  task automatic test_reset();
    n_checks += 7;
    if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
    if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
    if (bus_addr !== 7'h00) begin n_fail++; $display("FAIL rst_bus_addr: got %h want 00", bus_addr); end
    if (bus_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_bus_wdata: got %h want 00", bus_wdata); end
    if (bus_we !== 1'b0) begin n_fail++; $display("FAIL rst_bus_we: got %b want 0", bus_we); end
    if (bus_re !== 1'b0) begin n_fail++; $display("FAIL rst_bus_re: got %b want 0", bus_re); end
    if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
  endtask

  task automatic add_write_frame(input logic [7:0] cmd, input int nbytes);
    logic [7:0] d;
    frame_q = {cmd};
    for (int i = 0; i < nbytes; i++) begin
      d = 8'($urandom);
      frame_q.push_back(d);
      exp_addr.push_back(7'((int'(cmd[6:0]) + i) % 128));
      exp_data.push_back(d);
    end
  endtask

  task automatic test_write();
    wlog_addr.delete(); wlog_data.delete(); exp_addr.delete(); exp_data.delete();
    ack_delay = 2;
    frame_q = '{8'h85, 8'h11, 8'h22};
    exp_addr.push_back(7'd5); exp_data.push_back(8'h11);
    exp_addr.push_back(7'd6); exp_data.push_back(8'h22);
    send_frame();
    frame_q = '{8'hFF, 8'hA1, 8'hA2};
    exp_addr.push_back(7'd127); exp_data.push_back(8'hA1);
    exp_addr.push_back(7'd0);   exp_data.push_back(8'hA2);
    send_frame();
    for (int f = 0; f < 5; f++) begin
      ack_delay = $urandom_range(0, 6);
      add_write_frame(8'h80 | 8'($urandom_range(0, 127)), $urandom_range(1, 4));
      send_frame();
    end
    n_checks++;
    if (wlog_addr.size() != exp_addr.size()) begin
      n_fail++;
      $display("FAIL write_count: got %0d writes want %0d", wlog_addr.size(), exp_addr.size());
    end else begin
      foreach (exp_addr[i]) begin
        n_checks++;
        if (wlog_addr[i] !== exp_addr[i] || wlog_data[i] !== exp_data[i]) begin
          n_fail++;
          $display("FAIL write_%0d: got addr %0d data %h want addr %0d data %h",
                   i, wlog_addr[i], wlog_data[i], exp_addr[i], exp_data[i]);
        end
      end
    end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL write_err: got %b want 0", err); end
    wlog_addr.delete(); wlog_data.delete(); exp_addr.delete(); exp_data.delete();
  endtask

  task automatic read_frame(input logic [6:0] addr, input string tag);
    int t0, r0;
    t0 = tx_cnt; r0 = re_starts;
    frame_begin();
    send_byte({1'b0, addr});
    wait_idle();
    send_byte(8'($urandom));
    tick(4);
    frame_close();
    n_checks += 3;
    if (tx_cnt !== t0 + 1) begin n_fail++; $display("FAIL %s_tx_pulses: got %0d want 1", tag, tx_cnt - t0); end
    if (tx_last !== mem[addr]) begin n_fail++; $display("FAIL %s_tx_data: got %h want %h", tag, tx_last, mem[addr]); end
    if (re_starts !== r0 + 1) begin n_fail++; $display("FAIL %s_reads: got %0d want 1", tag, re_starts - r0); end
  endtask

  task automatic test_read();
    ack_delay = 2;
    mem[3] = 8'h5A;
    read_frame(7'd3, "read3");
    for (int k = 0; k < 4; k++) begin
      ack_delay = $urandom_range(0, 6);
      read_frame(7'($urandom_range(0, 127)), "read_rand");
    end
    n_checks += 2;
    if (wlog_addr.size() != 0) begin n_fail++; $display("FAIL read_no_write: got %0d writes want 0", wlog_addr.size()); end
    if (err !== 1'b0) begin n_fail++; $display("FAIL read_err: got %b want 0", err); end
  endtask

  task automatic test_early_frame_end();
    ack_delay = 10;
    frame_begin();
    send_byte(8'h81);
    send_byte(8'h33);
    cs = 1'b1;
    tick(6);
    n_checks++;
    if (bus_we !== 1'b1) begin n_fail++; $display("FAIL early_we_held: got %b want 1", bus_we); end
    wait_idle();
    tick(4);
    ack_delay = 2;
    mem[4] = 8'($urandom);
    read_frame(7'd4, "early_read");
    n_checks++;
    if (wlog_addr.size() != 1 || wlog_addr[0] !== 7'd1 || wlog_data[0] !== 8'h33) begin
      n_fail++;
      $display("FAIL early_write: got %0d writes (first addr %0d data %h) want 1 write addr 1 data 33",
               wlog_addr.size(), wlog_addr.size() ? wlog_addr[0] : 7'd0, wlog_data.size() ? wlog_data[0] : 8'd0);
    end
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL early_err: got %b want 0", err); end
    wlog_addr.delete(); wlog_data.delete();
  endtask

  task automatic test_overrun();
    ack_delay = 6;
    frame_begin();
    send_byte(8'h90);
    send_byte(8'h44);
    send_byte(8'h55);
    wait_idle();
    frame_close();
    n_checks += 2;
    if (wlog_addr.size() != 1 || wlog_addr[0] !== 7'h10 || wlog_data[0] !== 8'h44) begin
      n_fail++;
      $display("FAIL overrun_write: got %0d writes want 1 write addr 10 data 44", wlog_addr.size());
    end
    if (err !== 1'b1) begin n_fail++; $display("FAIL overrun_err: got %b want 1", err); end
    wlog_addr.delete(); wlog_data.delete();
    do_reset();
  endtask

  task automatic test_read_timeout();
    int n, t0;
    ack_en = 1'b0;
    t0 = tx_cnt;
    frame_begin();
    send_byte(8'h02);
    n = 0;
    while (bus_re && n < 3 * TO) begin tick(); n++; end
    tick(2);
    frame_close();
    n_checks += 4;
    if (n != TO) begin n_fail++; $display("FAIL timeout_len: bus_re held %0d cycles want %0d", n, TO); end
    if (tx_last !== 8'hEE || tx_cnt !== t0 + 1) begin
      n_fail++; $display("FAIL timeout_tx: got %h (%0d pulses) want ee (1 pulse)", tx_last, tx_cnt - t0);
    end
    if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b want 1", err); end
    if (bus_addr !== 7'd3) begin n_fail++; $display("FAIL timeout_addr: got %0d want 3", bus_addr); end
    ack_en = 1'b1;
    do_reset();
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", err); end
  endtask

  task automatic test_reset_mid_request();
    ack_en = 1'b0;
    frame_begin();
    send_byte(8'h8A);
    send_byte(8'h66);
    tick(3);
    n_checks++;
    if (bus_we !== 1'b1) begin n_fail++; $display("FAIL midrst_we_before: got %b want 1", bus_we); end
    rst = 1'b1;
    tick(1);
    n_checks++;
    if (bus_we !== 1'b0) begin n_fail++; $display("FAIL midrst_we_drop: got %b want 0", bus_we); end
    rst = 1'b0;
    force_ack = 1'b1;
    tick(3);
    force_ack = 1'b0;
    tick(2);
    n_checks += 4;
    if (bus_we !== 1'b0 || bus_re !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: we=%b re=%b want 0 0", bus_we, bus_re); end
    if (bus_addr !== 7'd0) begin n_fail++; $display("FAIL midrst_addr: got %0d want 0", bus_addr); end
    if (err !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b want 0", err); end
    if (wlog_addr.size() != 0) begin n_fail++; $display("FAIL midrst_write: got %0d writes want 0", wlog_addr.size()); end
    frame_close();
    ack_en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; cs = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    do_reset();
    test_reset();
    test_write();
    test_read();
    test_early_frame_end();
    test_overrun();
    test_read_timeout();
    test_reset_mid_request();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
